// File: rtl/if_stage.sv
// Fetch stage + IF/ID register: next PC is applied one edge after a redirect, and its word reaches IF/ID one edge later.
// stall freezes PC, IF/ID and the fetch counter; redirects presented during a stall are dropped.
module if_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter bit          DELAY_SLOT = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        isBranchTaken,
   input  logic        isJump,
   input  logic        isJumpRegister,
   input  logic [31:0] idPc4,
   input  logic [31:0] idImmediate,
   input  logic [25:0] jumpIndex,
   input  logic [31:0] registerA,
   output logic [31:0] imemAddress,
   input  logic [31:0] imemData,
   output logic [31:0] ifInstruction,
   output logic [31:0] pc,
   output logic [31:0] instruction,
   output logic [31:0] pc_4,
   output logic        valid,
   output logic [31:0] fetchCount
);

   logic [31:0] r_pc;
   logic [31:0] r_instruction;
   logic [31:0] r_pc_4;
   logic        r_valid;
   logic [31:0] r_fetch_count;

   logic [31:0] w_seq_target;
   logic [31:0] w_branch_target;
   logic [31:0] w_jump_target;
   logic [31:0] w_jr_target;
   logic [31:0] w_next_pc;
   logic        w_redirect;
   logic        w_squash;
   logic        w_unused;

   assign w_seq_target    = r_pc + 32'd4;
   assign w_branch_target = idPc4 + {idImmediate[29:0], 2'b00};
   assign w_jump_target   = {idPc4[31:28], jumpIndex, 2'b00};
   assign w_jr_target     = {registerA[31:2], 2'b00};
   assign w_redirect      = isJumpRegister | isJump | isBranchTaken;
   assign w_squash        = w_redirect && !DELAY_SLOT;
   assign w_unused        = ^{idImmediate[31:30], registerA[1:0]};

   always_comb begin
      w_next_pc = w_seq_target;
      if (isJumpRegister)
         w_next_pc = w_jr_target;
      else if (isJump)
         w_next_pc = w_jump_target;
      else if (isBranchTaken)
         w_next_pc = w_branch_target;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_instruction <= 32'h0;
         r_pc_4        <= 32'h0;
         r_valid       <= 1'b0;
         r_fetch_count <= 32'h0;
      end else if (!stall) begin
         r_pc   <= w_next_pc;
         r_pc_4 <= w_seq_target;
         // Without a delay slot the word fetched alongside the redirect is wrong-path.
         if (w_squash) begin
            r_instruction <= 32'h0;
            r_valid       <= 1'b0;
         end else begin
            r_instruction <= imemData;
            r_valid       <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
         end
      end
   end

   assign imemAddress   = r_pc;
   assign ifInstruction = imemData;
   assign pc            = r_pc;
   assign instruction   = r_instruction;
   assign pc_4          = r_pc_4;
   assign valid         = r_valid;
   assign fetchCount    = r_fetch_count;

endmodule
